pipe_stage_skid: RTL

Parametrised elastic pipeline-stage register for the 5-stage CPU. It is the successor to the fixed inter-stage latches and is intended first for the MEM→WB boundary.
- Carries an opaque DATA_W-bit payload (the packed stage bundle) with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under back-pressure.
- Synchronous flush inserts bubbles.
- Invalid output always carries an all-zero payload, so downstream write-enable fields read 0.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipe_stage_skid.sv | 87 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: the MEM/WB bundle layout
// (field widths, LSB offsets, total width) plus a packing helper.
package pipe_pkg;

    // MEM/WB bundle, LSB first:
    // reg_write | num_write | s_data_write | pc | data_read | c
    localparam int REG_WRITE_W    = 1;
    localparam int NUM_WRITE_W    = 5;
    localparam int S_DATA_WRITE_W = 2;
    localparam int PC_W           = 32;
    localparam int DATA_READ_W    = 32;
    localparam int C_W            = 32;

    localparam int REG_WRITE_LSB    = 0;
    localparam int NUM_WRITE_LSB    = REG_WRITE_LSB + REG_WRITE_W;
    localparam int S_DATA_WRITE_LSB = NUM_WRITE_LSB + NUM_WRITE_W;
    localparam int PC_LSB           = S_DATA_WRITE_LSB + S_DATA_WRITE_W;
    localparam int DATA_READ_LSB    = PC_LSB + PC_W;
    localparam int C_LSB            = DATA_READ_LSB + DATA_READ_W;

    localparam int MEMWB_W = 104;

    function automatic logic [MEMWB_W-1:0] memwb_pack(
        input logic [C_W-1:0]            c,
        input logic [DATA_READ_W-1:0]    data_read,
        input logic [PC_W-1:0]           pc,
        input logic [S_DATA_WRITE_W-1:0] s_data_write,
        input logic [NUM_WRITE_W-1:0]    num_write,
        input logic                      reg_write
    );
        return {c, data_read, pc, s_data_write, num_write, reg_write};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: clock, reset, inc (count enable), count (current value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (inc && count != {W{1'b1}}) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer and flush.
// Ports: clock, reset (sync, active-high), flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, occupancy (0..2), and stall_cnt which
// exists only when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int STAT_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [STAT_W-1:0] stall_cnt
`endif
);

    if (DATA_W < 1 || STAT_W < 1) begin : g_bad_param
        $error("pipe_stage_skid: DATA_W and STAT_W must be >= 1");
    end

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              push;
    logic              pop;

    assign in_ready  = !skid_valid;
    assign push      = in_valid && !skid_valid;
    assign pop       = main_valid && out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    // Data registers are cleared whenever their valid drops, so an
    // empty stage always presents an all-zero payload downstream.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!main_valid) begin
            if (push) begin
                main_valid <= 1'b1;
                main_data  <= in_data;
            end
        end else if (pop) begin
            if (skid_valid) begin
                main_data  <= skid_data;
                skid_valid <= 1'b0;
                skid_data  <= '0;
            end else if (push) begin
                main_data  <= in_data;
            end else begin
                main_valid <= 1'b0;
                main_data  <= '0;
            end
        end else if (push) begin
            // Main is stalled and skid is empty (push implies that).
            skid_valid <= 1'b1;
            skid_data  <= in_data;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    sat_counter #(
        .W(STAT_W)
    ) u_stall_cnt (
        .clock(clock),
        .reset(reset),
        .inc  (main_valid && !out_ready),
        .count(stall_cnt)
    );
`endif

endmodule
